// File: rtl/mem_access_seq_if.sv
// Request/response and memory-side bus between EX, the access sequencer and MEM.
interface mem_access_seq_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [AW-1:0] Address;
  logic [DW-1:0] write_data;
  logic          MemRead;
  logic          memWrite;
  logic [DW-1:0] read_data;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  // Environment side: EX stage requester plus the MEM block's read port
  modport master (
    output req_valid, req_write, req_addr, req_wdata, read_data,
    input  req_ready, Address, write_data, MemRead, memWrite,
    input  rsp_valid, rsp_rdata, rsp_err
  );

  // Sequencer side
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, read_data,
    output req_ready, Address, write_data, MemRead, memWrite,
    output rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_access_seq.sv
// Load/store sequencer in front of the data memory: setup/strobe/hold timing,
// MDR capture of loaded words, and rejection of misaligned/out-of-range addresses.
module mem_access_seq #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] ADDR_LIMIT  = 32'h0000_0400
) (
  input logic             clk,
  input logic             rst,
  mem_access_seq_if.slave bus
);
  localparam int unsigned DW = 32;
  localparam int unsigned CW = (WAIT_CYCLES > 4) ? $clog2(WAIT_CYCLES) : 2;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   mar_q, mar_d;
  logic [DW-1:0]   wdr_q, wdr_d;
  logic [DW-1:0]   mdr_q, mdr_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            wr_q, wr_d;
  logic            err_q, err_d;
  logic            ready_q, ready_d;
  logic            rd_stb_q, rd_stb_d;
  logic            wr_stb_q, wr_stb_d;
  logic            vld_q, vld_d;
  logic            rerr_q, rerr_d;
  logic            bad_addr_c;

  assign bad_addr_c = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr >= ADDR_LIMIT);

  // Next-state, datapath latches and next registered outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mar_d   = mar_q;
    wdr_d   = wdr_q;
    mdr_d   = mdr_q;
    wr_d    = wr_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          mar_d   = bus.req_addr;
          wdr_d   = bus.req_wdata;
          wr_d    = bus.req_write;
          err_d   = bad_addr_c;
          state_d = bad_addr_c ? RESP : SETUP;
        end
      end
      SETUP: begin
        cnt_d   = CW'(WAIT_CYCLES - 1);
        state_d = STROBE;
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          if (!wr_q) mdr_d = bus.read_data;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLD:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the upcoming state so they line up with it
    ready_d  = (state_d == IDLE);
    rd_stb_d = (state_d == STROBE) && !wr_d;
    wr_stb_d = (state_d == STROBE) && wr_d;
    vld_d    = (state_d == RESP);
    rerr_d   = (state_d == RESP) && err_d;
    rdata_d  = ((state_d == RESP) && !err_d && !wr_d) ? mdr_d : '0;
  end

  // State and output registers; reset aborts any transfer in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mar_q    <= '0;
      wdr_q    <= '0;
      mdr_q    <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
      rd_stb_q <= 1'b0;
      wr_stb_q <= 1'b0;
      vld_q    <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mar_q    <= mar_d;
      wdr_q    <= wdr_d;
      mdr_q    <= mdr_d;
      wr_q     <= wr_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      rd_stb_q <= rd_stb_d;
      wr_stb_q <= wr_stb_d;
      vld_q    <= vld_d;
      rerr_q   <= rerr_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.Address    = mar_q;
  assign bus.write_data = wdr_q;
  assign bus.MemRead    = rd_stb_q;
  assign bus.memWrite   = wr_stb_q;
  assign bus.rsp_valid  = vld_q;
  assign bus.rsp_rdata  = rdata_q;
  assign bus.rsp_err    = rerr_q;
endmodule

// File: tb/tb_mem_access_seq.sv
// Randomized bench for mem_access_seq: two instances (WAIT_CYCLES 1 and 3) share
// stimulus; each has a word-array MEM stand-in and a transaction-level timing model.
module tb_mem_access_seq;
  localparam logic [31:0] LIMIT = 32'h0000_0400;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr  = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] junk      = '0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  // Garbage on read_data whenever MemRead is low, so mistimed sampling shows up
  always @(negedge clk) junk <= $urandom;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned W = (g == 0) ? 1 : 3;

    mem_access_seq_if bus ();
    logic [31:0] mem [256];

    mem_access_seq #(.WAIT_CYCLES(W), .ADDR_LIMIT(LIMIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    assign bus.req_valid = req_valid;
    assign bus.req_write = req_write;
    assign bus.req_addr  = req_addr;
    assign bus.req_wdata = req_wdata;
    assign bus.read_data = bus.MemRead ? mem[bus.Address[9:2]] : junk;

    // MEM stand-in: word array written while memWrite is high
    always @(posedge clk) begin
      if (rst) for (int i = 0; i < 256; i++) mem[i] <= '0;
      else if (bus.memWrite) mem[bus.Address[9:2]] <= bus.write_data;
    end

    // Reference: a request occupies cycles 1..len after acceptance, strobe in
    // cycles 2..W+1, response in cycle len; memory contents tracked per word
    logic        seen_rst = 1'b0;
    logic        busy     = 1'b0;
    logic        m_err    = 1'b0;
    logic        m_wr     = 1'b0;
    int unsigned k        = 0;
    int unsigned m_len    = 0;
    logic [31:0] m_mar    = '0;
    logic [31:0] m_wdr    = '0;
    logic [31:0] m_rdata  = '0;
    logic [31:0] ref_mem [256];

    always @(posedge clk) begin
      if (rst) begin
        seen_rst = 1'b1;
        busy     = 1'b0;
        m_mar    = '0;
        m_wdr    = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
      end else if (busy) begin
        k++;
        if (k > m_len) busy = 1'b0;
      end else if (req_valid) begin
        busy  = 1'b1;
        k     = 1;
        m_mar = req_addr;
        m_wdr = req_wdata;
        m_wr  = req_write;
        m_err = (req_addr % 4 != 0) || (req_addr >= LIMIT);
        m_len = m_err ? 1 : W + 3;
        if (!m_err) begin
          if (m_wr) ref_mem[req_addr / 4] = req_wdata;
          else      m_rdata = ref_mem[req_addr / 4];
        end
      end
    end

    // Cycle-by-cycle comparison of every DUT output against the reference
    always @(negedge clk) begin
      logic in_rsp;
      logic strobe;
      if (seen_rst) begin
        in_rsp = busy && (k == m_len);
        strobe = busy && !m_err && (k >= 2) && (k <= W + 1);
        check($sformatf("w%0d_ready", W),    32'(bus.req_ready),  32'(!busy));
        check($sformatf("w%0d_memread", W),  32'(bus.MemRead),    32'(strobe && !m_wr));
        check($sformatf("w%0d_memwrite", W), 32'(bus.memWrite),   32'(strobe && m_wr));
        check($sformatf("w%0d_excl", W),     32'(bus.MemRead && bus.memWrite), 32'(0));
        check($sformatf("w%0d_address", W),  bus.Address,         m_mar);
        check($sformatf("w%0d_wdata", W),    bus.write_data,      m_wdr);
        check($sformatf("w%0d_rsp_valid", W), 32'(bus.rsp_valid), 32'(in_rsp));
        check($sformatf("w%0d_rsp_err", W),  32'(bus.rsp_err),    32'(in_rsp && m_err));
        check($sformatf("w%0d_rsp_rdata", W), bus.rsp_rdata,
              (in_rsp && !m_err && !m_wr) ? m_rdata : 32'h0);
      end
    end
  end

  // Wait until both instances are idle; while both are busy, spray ignored requests
  task automatic wait_idle();
    int n = 0;
    while ((g_dut[0].busy || g_dut[1].busy) && n < 60) begin
      if (g_dut[0].busy && g_dut[1].busy) begin
        req_valid = 1'($urandom_range(0, 1));
        req_write = 1'($urandom_range(0, 1));
        req_addr  = 32'($urandom_range(0, 255)) << 2;
        req_wdata = $urandom;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    check("idle_wait_timeout", 32'(g_dut[0].busy || g_dut[1].busy), 32'(0));
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
    wait_idle();
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic rnd_req(output logic w, output logic [31:0] a, output logic [31:0] d);
    int unsigned p = $urandom_range(0, 99);
    w = 1'($urandom_range(0, 1));
    d = $urandom;
    if (p < 60)      a = 32'($urandom_range(0, 15)) << 2;
    else if (p < 70) a = 32'h3F0 + (32'($urandom_range(0, 3)) << 2);
    else if (p < 85) a = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
    else             a = LIMIT + 32'($urandom_range(0, 1000));
  endtask

  initial begin
    logic        w;
    logic [31:0] a;
    logic [31:0] d;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed: store/load, both error kinds, top legal word
    send(1'b1, 32'h10,  32'hDEADBEEF);
    send(1'b0, 32'h10,  32'h0);
    send(1'b0, 32'h12,  32'h0);
    send(1'b0, 32'h400, 32'h0);
    send(1'b1, 32'h400, 32'h1111_2222);
    send(1'b1, 32'h3FC, 32'hCAFEF00D);
    send(1'b0, 32'h3FC, 32'h0);

    // Randomized traffic with idle gaps
    for (int i = 0; i < 150; i++) begin
      rnd_req(w, a, d);
      send(w, a, d);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // req_valid held high with fields changing every cycle
    for (int i = 0; i < 80; i++) begin
      rnd_req(w, a, d);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      @(negedge clk);
    end
    req_valid = 1'b0;
    wait_idle();

    // Reset while a load is in its strobe cycle
    send(1'b1, 32'h20, 32'h1234_5678);
    send(1'b0, 32'h20, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send(1'b0, 32'h20, 32'h0);
    send(1'b1, 32'h24, 32'hA5A5_5A5A);
    send(1'b0, 32'h24, 32'h0);
    wait_idle();
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
